// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller: trap codes, PC select,
// mcause layout and the trap-drain FSM state.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [4:0] {
        INSTR_ADDR_MISALIGNED = 5'h00,
        INSTR_ACCESS_FAULT    = 5'h01,
        ILLEGAL_INSTR         = 5'h02,
        BREAKPOINT            = 5'h03,
        LOAD_ADDR_MISALIGNED  = 5'h04,
        LOAD_ACCESS_FAULT     = 5'h05,
        ECALL_M               = 5'h0B,
        MRET                  = 5'h10,
        NO_TRAP               = 5'h1F
    } exc_t;

    typedef enum logic [1:0] {
        PC_JUMP = 2'd0,
        PC_EXC  = 2'd1,
        PC_MEPC = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic       irq;
        logic [3:0] trap_code;
    } mcause_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } hctrl_state_t;

    function automatic pc_sel_t trap_pc_sel(input exc_t trap);
        return (trap == MRET) ? PC_MEPC : PC_EXC;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_prio_mux.sv
// fwd_prio_mux: priority forwarding mux for one EX operand; the lowest-index
// (youngest) producer stage wins.
module fwd_prio_mux
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic [REG_ADDR_W-1:0]              src_addr_i,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_FWD-1:0]                 write_rd_i,
    input  logic [NUM_FWD-1:0][XLEN-1:0]       data_i,
    output logic [NUM_FWD-1:0]                 sel_o,
    output logic [XLEN-1:0]                    data_o
);

    // Walk from oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        sel_o  = '0;
        data_o = '0;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (write_rd_i[i] && (rd_addr_i[i] != '0) && (rd_addr_i[i] == src_addr_i)) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                data_o   = data_i[i];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load scoreboard, stall/flush and trap-drain
// redirect. HAZARD_CTRL_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FWD         = 2,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [REG_ADDR_W-1:0]              id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]              id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0]              id_rd_addr_i,
    input  logic                               id_write_rd_i,
    input  logic [REG_ADDR_W-1:0]              id_ex_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]              id_ex_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0]              id_ex_rd_addr_i,
    input  logic                               id_ex_load_i,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] fwd_rd_addr_i,
    input  logic [NUM_FWD-1:0]                 fwd_write_rd_i,
    input  logic [NUM_FWD-1:0][XLEN-1:0]       fwd_data_i,
    output logic [NUM_FWD-1:0]                 fwd_rs1_sel_o,
    output logic [NUM_FWD-1:0]                 fwd_rs2_sel_o,
    output logic [XLEN-1:0]                    fwd_rs1_data_o,
    output logic [XLEN-1:0]                    fwd_rs2_data_o,
    input  logic                               lsu_issue_i,
    input  logic [REG_ADDR_W-1:0]              lsu_issue_rd_i,
    input  logic                               lsu_done_i,
    input  logic [REG_ADDR_W-1:0]              lsu_done_rd_i,
    input  logic                               ex_new_pc_en_i,
    input  exc_t                               mem_trap_i,
    input  logic                               instr_valid_i,
    input  logic                               id_is_csr_i,
    input  logic                               ex_is_csr_i,
    input  logic                               mem_is_csr_i,
    output logic                               new_pc_en_o,
    output pc_sel_t                            pc_sel_o,
    output logic                               csr_mret_o,
    output logic                               is_trap_o,
    output mcause_t                            csr_mcause_o,
    output logic                               if_id_stall_o,
    output logic                               if_id_flush_o,
    output logic                               id_ex_stall_o,
    output logic                               id_ex_flush_o,
    output logic                               ex_mem_stall_o,
    output logic                               ex_mem_flush_o,
    output logic                               lsu_full_o,
    output logic [31:0]                        stall_cycles_o,
    output logic [31:0]                        flush_cycles_o,
    output hctrl_state_t                       dbg_state_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    hctrl_state_t     state_q, state_d;
    exc_t             trap_q, trap_d;
    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             hazard_stall;

    fwd_prio_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs1 (
        .src_addr_i (id_ex_rs1_addr_i),
        .rd_addr_i  (fwd_rd_addr_i),
        .write_rd_i (fwd_write_rd_i),
        .data_i     (fwd_data_i),
        .sel_o      (fwd_rs1_sel_o),
        .data_o     (fwd_rs1_data_o)
    );

    fwd_prio_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs2 (
        .src_addr_i (id_ex_rs2_addr_i),
        .rd_addr_i  (fwd_rd_addr_i),
        .write_rd_i (fwd_write_rd_i),
        .data_i     (fwd_data_i),
        .sel_o      (fwd_rs2_sel_o),
        .data_o     (fwd_rs2_data_o)
    );

    assign lsu_full_o = (outstanding_q == CNT_MAX);

    // Issue is applied after done so a same-register issue/done leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (lsu_done_i)  busy_d[lsu_done_rd_i]  = 1'b0;
        if (lsu_issue_i) busy_d[lsu_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        if (lsu_issue_i && !lsu_done_i && !lsu_full_o)
            outstanding_d = outstanding_q + 1'b1;
        else if (lsu_done_i && !lsu_issue_i && (outstanding_q != '0))
            outstanding_d = outstanding_q - 1'b1;
    end

    assign hazard_stall =
        (id_ex_load_i && (id_ex_rd_addr_i != '0) &&
         ((id_ex_rd_addr_i == id_rs1_addr_i) || (id_ex_rd_addr_i == id_rs2_addr_i))) ||
        busy_q[id_rs1_addr_i] || busy_q[id_rs2_addr_i] ||
        (id_write_rd_i && busy_q[id_rd_addr_i]) ||
        (lsu_full_o && id_ex_load_i);

    always_comb begin
        state_d                = state_q;
        trap_d                 = trap_q;
        new_pc_en_o            = 1'b0;
        pc_sel_o               = PC_JUMP;
        csr_mret_o             = 1'b0;
        is_trap_o              = 1'b0;
        if_id_stall_o          = 1'b0;
        if_id_flush_o          = 1'b0;
        id_ex_flush_o          = 1'b0;
        ex_mem_flush_o         = 1'b0;
        csr_mcause_o.irq       = 1'b0;
        csr_mcause_o.trap_code = mem_trap_i[3:0];
        case (state_q)
            RUN: begin
                if_id_stall_o = hazard_stall | ex_is_csr_i | mem_is_csr_i;
                if_id_flush_o = id_is_csr_i | ex_is_csr_i | mem_is_csr_i;
                if (mem_trap_i == NO_TRAP) begin
                    new_pc_en_o   = ex_new_pc_en_i;
                    id_ex_flush_o = ex_new_pc_en_i | !instr_valid_i | hazard_stall;
                end else begin
                    id_ex_flush_o  = 1'b1;
                    ex_mem_flush_o = 1'b1;
                    if (outstanding_q == '0) begin
                        new_pc_en_o = 1'b1;
                        pc_sel_o    = trap_pc_sel(mem_trap_i);
                        csr_mret_o  = (mem_trap_i == MRET);
                        is_trap_o   = (mem_trap_i != MRET);
                    end else begin
                        trap_d  = mem_trap_i;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                if (outstanding_d == '0) state_d = REDIRECT;
            end
            REDIRECT: begin
                new_pc_en_o            = 1'b1;
                pc_sel_o               = trap_pc_sel(trap_q);
                csr_mret_o             = (trap_q == MRET);
                is_trap_o              = (trap_q != MRET);
                id_ex_flush_o          = 1'b1;
                ex_mem_flush_o         = 1'b1;
                csr_mcause_o.trap_code = trap_q[3:0];
                trap_d                 = NO_TRAP;
                state_d                = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign id_ex_stall_o  = 1'b0;
    assign ex_mem_stall_o = 1'b0;
    assign dbg_state_o    = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            trap_q        <= NO_TRAP;
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            trap_q        <= trap_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    // The in-flight counter must never be asked to wrap or underflow.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(lsu_issue_i && !lsu_done_i && lsu_full_o));
            assert (!(lsu_done_i && !lsu_issue_i && (outstanding_q == '0)));
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, flush_cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            if (if_id_stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (id_ex_flush_o) flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cycles_o = flush_cycles_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: forwarding, load-use, scoreboard,
// trap drain, backpressure, reset mid-drain and MRET.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int NUM_FWD = 2;
    localparam int XLEN    = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [4:0]              id_rs1, id_rs2, id_rd;
    logic                    id_write_rd;
    logic [4:0]              id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic                    id_ex_load;
    logic [NUM_FWD-1:0][4:0] fwd_rd_addr;
    logic [NUM_FWD-1:0]      fwd_write_rd;
    logic [NUM_FWD-1:0][XLEN-1:0] fwd_data;
    logic [NUM_FWD-1:0]      fwd_rs1_sel, fwd_rs2_sel;
    logic [XLEN-1:0]         fwd_rs1_data, fwd_rs2_data;
    logic                    lsu_issue, lsu_done;
    logic [4:0]              lsu_issue_rd, lsu_done_rd;
    logic                    ex_new_pc_en;
    exc_t                    mem_trap;
    logic                    instr_valid;
    logic                    id_is_csr, ex_is_csr, mem_is_csr;
    logic                    new_pc_en;
    pc_sel_t                 pc_sel;
    logic                    csr_mret, is_trap;
    mcause_t                 mcause;
    logic                    if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic                    ex_mem_stall, ex_mem_flush, lsu_full;
    logic [31:0]             stall_cycles, flush_cycles;
    hctrl_state_t            dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd),
        .id_write_rd_i(id_write_rd),
        .id_ex_rs1_addr_i(id_ex_rs1), .id_ex_rs2_addr_i(id_ex_rs2), .id_ex_rd_addr_i(id_ex_rd),
        .id_ex_load_i(id_ex_load),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_write_rd_i(fwd_write_rd), .fwd_data_i(fwd_data),
        .fwd_rs1_sel_o(fwd_rs1_sel), .fwd_rs2_sel_o(fwd_rs2_sel),
        .fwd_rs1_data_o(fwd_rs1_data), .fwd_rs2_data_o(fwd_rs2_data),
        .lsu_issue_i(lsu_issue), .lsu_issue_rd_i(lsu_issue_rd),
        .lsu_done_i(lsu_done), .lsu_done_rd_i(lsu_done_rd),
        .ex_new_pc_en_i(ex_new_pc_en), .mem_trap_i(mem_trap), .instr_valid_i(instr_valid),
        .id_is_csr_i(id_is_csr), .ex_is_csr_i(ex_is_csr), .mem_is_csr_i(mem_is_csr),
        .new_pc_en_o(new_pc_en), .pc_sel_o(pc_sel), .csr_mret_o(csr_mret),
        .is_trap_o(is_trap), .csr_mcause_o(mcause),
        .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
        .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
        .ex_mem_stall_o(ex_mem_stall), .ex_mem_flush_o(ex_mem_flush),
        .lsu_full_o(lsu_full), .stall_cycles_o(stall_cycles), .flush_cycles_o(flush_cycles),
        .dbg_state_o(dbg_state)
    );

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_write_rd = 1'b0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0; id_ex_load = 1'b0;
        fwd_rd_addr = '0; fwd_write_rd = '0; fwd_data = '0;
        lsu_issue = 1'b0; lsu_issue_rd = '0; lsu_done = 1'b0; lsu_done_rd = '0;
        ex_new_pc_en = 1'b0; mem_trap = NO_TRAP; instr_valid = 1'b1;
        id_is_csr = 1'b0; ex_is_csr = 1'b0; mem_is_csr = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_drive(input logic iss, input logic [4:0] ird,
                             input logic dn, input logic [4:0] drd);
        lsu_issue = iss; lsu_issue_rd = ird; lsu_done = dn; lsu_done_rd = drd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        instr_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({new_pc_en, csr_mret, is_trap, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_flush, ex_mem_stall, ex_mem_flush, lsu_full} !== 10'b0000001000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {new_pc_en, csr_mret, is_trap,
                     if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
                     ex_mem_flush, lsu_full}, 10'b0000001000);
        end
        checks++;
        if (pc_sel !== PC_JUMP || dbg_state !== RUN) begin
            errors++;
            $display("FAIL reset_state: got pc_sel %0d state %0d expected 0 0", pc_sel, dbg_state);
        end
        checks++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d %0d expected 0 0", stall_cycles, flush_cycles);
        end
        next_cycle();
        rst = 1'b0;
        instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (id_ex_flush !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: got %b expected 0", id_ex_flush);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        fwd_rd_addr[0] = 5'd3; fwd_rd_addr[1] = 5'd3; fwd_write_rd = 2'b11;
        fwd_data[0] = 32'hAAAA; fwd_data[1] = 32'h5555;
        id_ex_rs1 = 5'd3; id_ex_rs2 = 5'd4;
        @(negedge clk);
        checks++;
        if ({fwd_rs1_sel, fwd_rs1_data, fwd_rs2_sel, fwd_rs2_data} !== {2'b01, 32'hAAAA, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL fwd_prio: got sel %b data %h / %b %h expected 01 aaaa / 00 0",
                     fwd_rs1_sel, fwd_rs1_data, fwd_rs2_sel, fwd_rs2_data);
        end
        fwd_write_rd = 2'b10; id_ex_rs2 = 5'd3;
        #1;
        checks++;
        if ({fwd_rs2_sel, fwd_rs2_data} !== {2'b10, 32'h5555}) begin
            errors++;
            $display("FAIL fwd_older: got %b %h expected 10 5555", fwd_rs2_sel, fwd_rs2_data);
        end
        fwd_write_rd = 2'b11; fwd_rd_addr[0] = 5'd0; fwd_rd_addr[1] = 5'd0;
        id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0;
        #1;
        checks++;
        if ({fwd_rs1_sel, fwd_rs1_data} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL fwd_x0: got %b %h expected 00 0", fwd_rs1_sel, fwd_rs1_data);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_load_use();
        id_ex_load = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5;
        @(negedge clk);
        checks++;
        if ({if_id_stall, id_ex_flush} !== 2'b11) begin
            errors++;
            $display("FAIL load_use: got %b expected 11", {if_id_stall, id_ex_flush});
        end
        next_cycle();
        id_ex_load = 1'b0; id_ex_rd = 5'd0;
        @(negedge clk);
        checks++;
        if ({if_id_stall, id_ex_flush} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_release: got %b expected 00", {if_id_stall, id_ex_flush});
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_scoreboard();
        logic [31:0] e;
        id_rs1 = 5'd7;
        for (int c = 0; c < 8; c++) begin
            lsu_drive(c == 0, 5'd7, c == 6, 5'd7);
            e = (c >= 1 && c <= 6) ? 32'd3 : 32'd0;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({30'd0, if_id_stall, id_ex_flush} !== e) begin
                errors++;
                $display("FAIL sb_stall c%0d: got %b%b expected %0d", c, if_id_stall, id_ex_flush, e);
            end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_branch_csr();
        ex_new_pc_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({new_pc_en, pc_sel, id_ex_flush, ex_mem_flush} !== {1'b1, PC_JUMP, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL branch: got %b%0d%b%b expected 1 0 1 0", new_pc_en, pc_sel, id_ex_flush, ex_mem_flush);
        end
        ex_new_pc_en = 1'b0; id_is_csr = 1'b1;
        #1;
        checks++;
        if ({if_id_stall, if_id_flush} !== 2'b01) begin
            errors++;
            $display("FAIL id_csr: got %b expected 01", {if_id_stall, if_id_flush});
        end
        id_is_csr = 1'b0; mem_is_csr = 1'b1;
        #1;
        checks++;
        if ({if_id_stall, if_id_flush} !== 2'b11) begin
            errors++;
            $display("FAIL mem_csr: got %b expected 11", {if_id_stall, if_id_flush});
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_trap_drain();
        logic [31:0] e;
        lsu_drive(1'b1, 5'd8, 1'b0, 5'd0);
        next_cycle();
        lsu_drive(1'b1, 5'd9, 1'b0, 5'd0);
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            mem_trap = (c == 0) ? ILLEGAL_INSTR : NO_TRAP;
            lsu_drive(1'b0, 5'd0, (c == 3) || (c == 5), (c == 3) ? 5'd8 : 5'd9);
            if (c == 0)      e = {23'd0, RUN,      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PC_JUMP};
            else if (c <= 5) e = {23'd0, DRAIN,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PC_JUMP};
            else if (c == 6) e = {23'd0, REDIRECT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, PC_EXC};
            else             e = {23'd0, RUN,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PC_JUMP};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({23'd0, dbg_state, new_pc_en, is_trap, if_id_stall, id_ex_flush, ex_mem_flush, pc_sel} !== e) begin
                errors++;
                $display("FAIL drain c%0d: got %b expected %b", c,
                         {dbg_state, new_pc_en, is_trap, if_id_stall, id_ex_flush, ex_mem_flush, pc_sel}, e[8:0]);
            end
            if (c == 6) begin
                checks++;
                if (mcause !== {1'b0, 4'd2}) begin
                    errors++;
                    $display("FAIL drain_mcause: got %h expected 02", mcause);
                end
            end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            lsu_drive(1'b1, 5'(10 + k), 1'b0, 5'd0);
            if (k == 3) begin
                @(negedge clk);
                checks++;
                if (lsu_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_early: got %b expected 0", lsu_full);
                end
            end
            next_cycle();
        end
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        id_ex_load = 1'b1;
        @(negedge clk);
        checks++;
        if ({lsu_full, if_id_stall} !== 2'b11) begin
            errors++;
            $display("FAIL full_stall: got %b expected 11", {lsu_full, if_id_stall});
        end
        id_ex_load = 1'b0;
        lsu_drive(1'b1, 5'd14, 1'b1, 5'd10);
        next_cycle();
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (lsu_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: got %b expected 1", lsu_full);
        end
        lsu_drive(1'b0, 5'd0, 1'b1, 5'd11);
        next_cycle();
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (lsu_full !== 1'b0) begin
            errors++;
            $display("FAIL full_release: got %b expected 0", lsu_full);
        end
        lsu_drive(1'b1, 5'd15, 1'b1, 5'd12);
        next_cycle();
        lsu_drive(1'b1, 5'd15, 1'b1, 5'd15);
        next_cycle();
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        id_rs1 = 5'd15;
        @(negedge clk);
        checks++;
        if (if_id_stall !== 1'b1) begin
            errors++;
            $display("FAIL issue_wins: got %b expected 1", if_id_stall);
        end
        for (int k = 0; k < 3; k++) begin
            lsu_drive(1'b0, 5'd0, 1'b1, 5'(13 + k));
            next_cycle();
        end
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if ({lsu_full, if_id_stall} !== 2'b00) begin
            errors++;
            $display("FAIL drained_sb: got %b expected 00", {lsu_full, if_id_stall});
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_reset_mid_drain();
        lsu_drive(1'b1, 5'd20, 1'b0, 5'd0);
        next_cycle();
        lsu_drive(1'b0, 5'd0, 1'b0, 5'd0);
        mem_trap = LOAD_ACCESS_FAULT;
        next_cycle();
        mem_trap = NO_TRAP;
        @(negedge clk);
        checks++;
        if (dbg_state !== DRAIN) begin
            errors++;
            $display("FAIL enter_drain: got %0d expected 1", dbg_state);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        id_rs1 = 5'd20;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({dbg_state, new_pc_en, if_id_stall, lsu_full} !== {RUN, 3'b000}) begin
                errors++;
                $display("FAIL rst_drain c%0d: got %b expected 00000", c,
                         {dbg_state, new_pc_en, if_id_stall, lsu_full});
            end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_mret();
        logic [31:0] exp_flush;
        rst = 1'b1;
        set_idle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        mem_trap = MRET;
        @(negedge clk);
        checks++;
        if ({new_pc_en, pc_sel, csr_mret, is_trap, id_ex_flush, ex_mem_flush} !==
            {1'b1, PC_MEPC, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mret: got %b expected 1101011",
                     {new_pc_en, pc_sel, csr_mret, is_trap, id_ex_flush, ex_mem_flush});
        end
        next_cycle();
        mem_trap = NO_TRAP;
`ifdef HAZARD_CTRL_PERF_EN
        exp_flush = 32'd1;
`else
        exp_flush = 32'd0;
`endif
        @(negedge clk);
        checks++;
        if (flush_cycles !== exp_flush || stall_cycles !== 32'd0 || dbg_state !== RUN) begin
            errors++;
            $display("FAIL mret_perf: got flush %0d stall %0d state %0d expected %0d 0 0",
                     flush_cycles, stall_cycles, dbg_state, exp_flush);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_scoreboard();
        test_branch_csr();
        test_trap_drain();
        test_backpressure();
        test_reset_mid_drain();
        test_mret();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised successor to the core's forwarding/hazard controller: a priority forwarding mux over `NUM_FWD` producer stages, a register scoreboard for variable-latency loads, and a trap-drain state machine.
- Sits beside the 5-stage pipeline.
- Drives operand forwarding into EX, stall/flush of IF/ID, ID/EX and EX/MEM, and PC redirection to fetch.
- Traps wait for every outstanding load to retire before the PC is redirected.

## Interface
Parameters:
- `NUM_FWD`, 2: forwarding source stages; index 0 is the youngest (EX/MEM).
- `XLEN`, 32: data width.
- `MAX_OUTSTANDING`, 4: maximum loads in flight in the LSU.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `id_rs1_addr_i`, `id_rs2_addr_i`, `id_rd_addr_i` in 5 each: ID-stage register addresses.
- `id_write_rd_i` in 1: ID instruction writes rd.
- `id_ex_rs1_addr_i`, `id_ex_rs2_addr_i`, `id_ex_rd_addr_i` in 5 each: ID/EX register addresses.
- `id_ex_load_i` in 1: ID/EX holds a load.
- `fwd_rd_addr_i` in `NUM_FWD`x5: producer rd address per stage.
- `fwd_write_rd_i` in `NUM_FWD`: producer writes rd.
- `fwd_data_i` in `NUM_FWD`x`XLEN`: producer result.
- `fwd_rs1_sel_o`, `fwd_rs2_sel_o` out `NUM_FWD`: one-hot forward select; all-zero means use the register-file value.
- `fwd_rs1_data_o`, `fwd_rs2_data_o` out `XLEN`: forwarded operand.
- `lsu_issue_i` in 1, `lsu_issue_rd_i` in 5: a load enters the LSU.
- `lsu_done_i` in 1, `lsu_done_rd_i` in 5: load data is written back.
- `ex_new_pc_en_i` in 1: branch/jump taken in EX.
- `mem_trap_i` in `exc_t`: trap raised in MEM.
- `instr_valid_i` in 1: fetch output is valid.
- `id_is_csr_i`, `ex_is_csr_i`, `mem_is_csr_i` in 1 each: a CSR instruction is in that stage.
- `new_pc_en_o` out 1, `pc_sel_o` out `pc_sel_t`: PC redirect to fetch.
- `csr_mret_o` out 1, `is_trap_o` out 1, `csr_mcause_o` out `mcause_t`: trap controls to the CS registers.
- `if_id_stall_o`, `if_id_flush_o`, `id_ex_stall_o`, `id_ex_flush_o`, `ex_mem_stall_o`, `ex_mem_flush_o` out 1 each: pipeline register controls.
- `lsu_full_o` out 1: `MAX_OUTSTANDING` loads are in flight.
- `stall_cycles_o`, `flush_cycles_o` out 32 each: performance counters.

## Operation
Forwarding (rs1 and rs2 each, independently):
- The lowest index i wins when `fwd_write_rd_i[i]` is set, `fwd_rd_addr_i[i]` is nonzero and it equals the ID/EX source address.
- The select output is one-hot; the data output is `fwd_data_i[i]`, or 0 when there is no hit.

Scoreboard:
- `busy[31:1]`: set on `lsu_issue_i` for rd≠0, cleared on `lsu_done_i`. x0 is never busy.
- `outstanding`: counter, `$clog2(MAX_OUTSTANDING+1)` bits. Incremented on issue, decremented on done; simultaneous issue and done leave it unchanged.
- `lsu_full_o = (outstanding == MAX_OUTSTANDING)`.

`hazard_stall` is asserted when any of these holds:
- load-use: `id_ex_load_i`, `id_ex_rd_addr_i`≠0, and it matches id rs1 or rs2;
- `busy` is set for id rs1 or rs2;
- WAW: `id_write_rd_i` and `busy[id_rd]`;
- `lsu_full_o` and `id_ex_load_i`.

State machine, states RUN / DRAIN / REDIRECT:
- RUN, `mem_trap_i == NO_TRAP`:
  - `new_pc_en_o = ex_new_pc_en_i`, `pc_sel_o = PC_JUMP`.
  - `if_id_stall_o = hazard_stall | ex_is_csr_i | mem_is_csr_i`.
  - `if_id_flush_o = id_is_csr_i | ex_is_csr_i | mem_is_csr_i`.
  - `id_ex_flush_o = ex_new_pc_en_i | !instr_valid_i | hazard_stall`.
  - `ex_mem_flush_o = 0`.
- RUN, trap with `outstanding == 0`:
  - Redirect in the same cycle. MRET gives `PC_MEPC` + `csr_mret_o`; any other trap gives `PC_EXC` + `is_trap_o`.
  - `id_ex_flush_o = ex_mem_flush_o = 1`. Stay in RUN.
- RUN, trap with `outstanding > 0`:
  - Latch `mem_trap_i` into `trap_q`; flush ID/EX and EX/MEM; go to DRAIN.
- DRAIN:
  - `if_id_stall_o`, `id_ex_flush_o` and `ex_mem_flush_o` held at 1; `new_pc_en_o = 0`.
  - Go to REDIRECT once `outstanding` reaches 0, including a done arriving in this cycle that brings it to 0.
- REDIRECT:
  - One cycle: redirect per `trap_q`, flush ID/EX and EX/MEM, return to RUN.
  - A new `mem_trap_i` in this cycle is ignored, because it was flushed.
- `csr_mcause_o`: `irq = 0`; `trap_code` is `trap_q[3:0]` in REDIRECT, otherwise `mem_trap_i[3:0]`.
- `id_ex_stall_o = ex_mem_stall_o = 0`.

## Timing
- Forwarding, stall, flush and the RUN-state redirect are combinational (zero latency).
- A drained trap redirects exactly one cycle after the cycle in which `outstanding` reaches 0.
- Reset, which overrides everything including a reset taken mid-DRAIN:
  - state = RUN, `busy = 0`, `outstanding = 0`, `trap_q = NO_TRAP`, counters = 0.
  - Outputs follow combinationally from those values: all controls 0 except `id_ex_flush_o = !instr_valid_i`, with `pc_sel_o = PC_JUMP`.
- The counter neither wraps nor underflows: an issue while full, or a done while empty, is an assertion error, and the counter holds its value.
- `lsu_issue_rd_i == lsu_done_rd_i` in the same cycle: `busy` ends set (the issue wins).

## Configuration
`HAZARD_CTRL_PERF_EN`:
- Defined: `stall_cycles_o` counts cycles with `if_id_stall_o` set; `flush_cycles_o` counts cycles with `id_ex_flush_o` set. Both are 32-bit, wrap, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- `riscv_pkg` / `csr_pkg` add `hctrl_state_t` (RUN, DRAIN, REDIRECT).
- `exc_t`, `pc_sel_t` and `mcause_t` are reused unchanged.
- One sub-module, `fwd_prio_mux`, instanced twice (rs1 and rs2), parametrised by `NUM_FWD` and `XLEN`.

## Test plan
- Forward priority:
  - Stimulus: `fwd_rd_addr_i = {x3, x3}`, both writing, `id_ex_rs1 = x3`, data `{0xAAAA, 0x5555}` (index 0 first).
  - Expected: `fwd_rs1_sel_o = 2'b01`, data `0xAAAA`.
  - Repeat with rd = x0: expected select 0.
- Load-use:
  - Stimulus: `id_ex_load_i`, `id_ex_rd = x5`, `id_rs2 = x5`.
  - Expected: `if_id_stall_o = 1` and `id_ex_flush_o = 1` for 1 cycle.
- Scoreboard:
  - Stimulus: issue a load to x7, `id_rs1 = x7`; `lsu_done_i` 6 cycles later.
  - Expected: stall held for 6 cycles, released the cycle after done.
- Trap drain:
  - Stimulus: 2 loads outstanding, `mem_trap_i = ILLEGAL_INSTR`; dones at +3 and +5.
  - Expected: DRAIN for 5 cycles, then `new_pc_en_o = 1`, `PC_EXC`, `is_trap_o = 1`, mcause code 2 at +6.
- Backpressure:
  - Stimulus: 4 issues give `lsu_full_o = 1`; then a simultaneous issue and done.
  - Expected: `outstanding` stays 4.
- MRET with no outstanding loads:
  - Expected: same-cycle `PC_MEPC`, `csr_mret_o = 1`.
  - With `HAZARD_CTRL_PERF_EN`: `flush_cycles_o` increments by 1.
